// File: rtl/psa_accumulator.sv
// Packed-SIMD accumulator: sums a run of 16-bit beats as four independent
// signed 4-bit lanes with per-lane saturation and overflow bookkeeping.
module psa_accumulator #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             error,
    output logic [3:0]       ovf_cnt
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned NUM_NIB = 4;
    localparam int unsigned DATA_W = NIB_W * NUM_NIB;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DATA_W-1:0]  sat_sum;
    logic               beat_ovf;

    // Returns {overflow, saturated sum} for one signed nibble lane.
    function automatic logic [NIB_W:0] sat_add(input logic [NIB_W-1:0] a,
                                               input logic [NIB_W-1:0] b);
        logic [NIB_W-1:0] s;
        logic             ovf;
        s   = a + b;
        ovf = (a[NIB_W-1] == b[NIB_W-1]) && (s[NIB_W-1] != a[NIB_W-1]);
        if (ovf) begin
            s = a[NIB_W-1] ? 4'h8 : 4'h7;
        end
        return {ovf, s};
    endfunction

    // Lane-wise saturating sum of the accumulator and the incoming beat.
    always_comb begin
        logic [NIB_W:0] lane;
        sat_sum  = '0;
        beat_ovf = 1'b0;
        lane     = '0;
        for (int i = 0; i < int'(NUM_NIB); i++) begin
            lane = sat_add(acc_q[i*NIB_W +: NIB_W], in_data[i*NIB_W +: NIB_W]);
            sat_sum[i*NIB_W +: NIB_W] = lane[NIB_W-1:0];
            beat_ovf = beat_ovf | lane[NIB_W];
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    err_d = 1'b0;
                    ovf_d = '0;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sat_sum;
                    if (beat_ovf) begin
                        err_d = 1'b1;
                        if (ovf_q != CNT_W'(15)) begin
                            ovf_d = ovf_q + CNT_W'(1);
                        end
                    end
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == ACCUM);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            ovf_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = acc_q;
    assign error    = err_q;
    assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_psa_accumulator.sv
// Bench for psa_accumulator: directed and random runs scored against a
// lane-by-lane integer model of saturating nibble accumulation.
module tb_psa_accumulator;

    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    logic             error;
    logic [3:0]       ovf_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] beats[$];
    logic [15:0] m_acc = '0;
    bit          m_err = 1'b0;
    int          m_cnt = 0;

    psa_accumulator #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .error    (error),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each lane treated as a plain integer, clamped to the 4-bit signed range.
    function automatic logic [15:0] model_beat(input logic [15:0] acc, input logic [15:0] d,
                                               output bit ovf);
        logic [15:0]       r;
        logic signed [3:0] a;
        logic signed [3:0] b;
        int                s;
        r   = '0;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = acc[4*i +: 4];
            b = d[4*i +: 4];
            s = int'(a) + int'(b);
            if (s > 7) begin
                s   = 7;
                ovf = 1'b1;
            end else if (s < -8) begin
                s   = -8;
                ovf = 1'b1;
            end
            r[4*i +: 4] = 4'(s);
        end
        return r;
    endfunction

    task automatic model_apply(input logic [15:0] d);
        bit o;
        m_acc = model_beat(m_acc, d, o);
        if (o) begin
            m_err = 1'b1;
            if (m_cnt < 15) m_cnt++;
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_result"}, 32'(result), 32'(m_acc));
        check({tag, "_error"}, 32'(error), 32'(m_err));
        check({tag, "_ovf"}, 32'(ovf_cnt), 32'(m_cnt));
    endtask

    // One complete run using the beats queue; poke drives ignored start/in_valid.
    task automatic run(input bit poke);
        int n;
        int gaps;
        n = beats.size();
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            tick();
            in_valid = 1'b0;
            check("idle_valid_busy", 32'(busy), 32'(0));
            check("idle_valid_result", 32'(result), 32'(m_acc));
        end
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
        m_acc = '0;
        m_err = 1'b0;
        m_cnt = 0;
        if (n == 0) begin
            check("zl_done", 32'(done), 32'(1));
            check("zl_ready", 32'(in_ready), 32'(0));
            check_flags("zl");
        end else begin
            check("start_ready", 32'(in_ready), 32'(1));
            check("start_busy", 32'(busy), 32'(1));
            check("start_done", 32'(done), 32'(0));
            check("start_clear", 32'(result), 32'(0));
            for (int k = 0; k < n; k++) begin
                gaps = poke ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
                for (int g = 0; g < gaps; g++) begin
                    if (poke) begin
                        start = 1'b1;
                        len   = LEN_W'($urandom);
                    end
                    tick();
                    start = 1'b0;
                    check("gap_ready", 32'(in_ready), 32'(1));
                    check("gap_done", 32'(done), 32'(0));
                    check_flags("gap");
                end
                in_valid = 1'b1;
                in_data  = beats[k];
                tick();
                in_valid = 1'b0;
                model_apply(beats[k]);
                check_flags("beat");
                check("beat_done", 32'(done), 32'(k == n - 1));
                check("beat_ready", 32'(in_ready), 32'(k != n - 1));
            end
        end
        check("done_busy", 32'(busy), 32'(1));
        if (poke) begin
            start    = 1'b1;
            len      = LEN_W'(3);
            in_valid = 1'b1;
            in_data  = 16'($urandom);
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("post_done", 32'(done), 32'(0));
        check("post_busy", 32'(busy), 32'(0));
        check("post_ready", 32'(in_ready), 32'(0));
        check_flags("post");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        check("rst_result", 32'(result), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ready", 32'(in_ready), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_ovf", 32'(ovf_cnt), 32'(0));
        rst = 1'b0;

        // Basic run, started on the first cycle out of reset.
        beats = '{16'h1234, 16'h1111};
        run(1'b0);
        check("basic_result", 32'(result), 32'(16'h2345));
        check("basic_error", 32'(error), 32'(0));

        // Saturation in both directions.
        beats = '{16'h7888, 16'h1FFF};
        run(1'b0);
        check("sat_result", 32'(result), 32'(16'h7888));
        check("sat_error", 32'(error), 32'(1));
        check("sat_ovf", 32'(ovf_cnt), 32'(1));

        // Zero length.
        beats = {};
        run(1'b0);

        // Backpressure plus ignored start / in_valid.
        beats = '{16'h0001, 16'h0001, 16'h0001};
        run(1'b1);
        check("bp_result", 32'(result), 32'(16'h0003));

        // Maximum length with repeated overflow.
        beats = {};
        for (int k = 0; k < 15; k++) beats.push_back(16'h7777);
        run(1'b0);
        check("max_ovf", 32'(ovf_cnt), 32'(14));

        // Reset mid-run discards the partial result.
        start = 1'b1;
        len   = LEN_W'(4);
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0101;
            tick();
        end
        check("mid_partial", 32'(result), 32'(16'h0202));
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        m_acc = '0;
        m_err = 1'b0;
        m_cnt = 0;
        check("mid_rst_result", 32'(result), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_ready", 32'(in_ready), 32'(0));
        tick();
        check("mid_idle_done", 32'(done), 32'(0));
        check("mid_idle_busy", 32'(busy), 32'(0));
        beats = '{16'h1111, 16'h2222};
        run(1'b0);
        check("mid_fresh", 32'(result), 32'(16'h3333));

        // Random runs.
        for (int r = 0; r < 30; r++) begin
            beats = {};
            for (int k = 0; k < int'($urandom_range(0, 15)); k++) begin
                beats.push_back(16'($urandom));
            end
            run(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
